// File: rtl/sprite_pkg.sv
// Shared types and constants for the player-sprite renderer.
package sprite_pkg;

  typedef enum logic [1:0] {GROUND, RISE, FALL, LAND} jump_state_e;

  // Sprite ROM word layout.
  typedef struct packed {
    logic [3:0] blue;
    logic [3:0] green;
    logic [3:0] red;
  } rgb_t;

  localparam logic [11:0]   TRANSPARENT_KEY = 12'hC0F;
  localparam logic [3:0]    COLOUR_BG       = 4'hF;
  localparam int unsigned   JUMP_POSES      = 5;

endpackage

// File: rtl/sprite_jump_physics.sv
// Frame-tick driven jump state machine: pending latch, height/velocity/speed
// integration, landing counter and jump pose index.
module sprite_jump_physics
  import sprite_pkg::*;
#(
  parameter int unsigned ROW_W       = 11,
  parameter int unsigned JUMP_V0     = 22,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned LAND_FRAMES = 3,
  parameter int unsigned MAX_H       = 562
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             key_rise,
  output jump_state_e      state,
  output logic [ROW_W-1:0] height,
  output logic             airborne,
  output logic [2:0]       jump_idx_c
);

  localparam int unsigned      LC_W    = (LAND_FRAMES > 1) ? $clog2(LAND_FRAMES) : 1;
  localparam logic [ROW_W-1:0] GRAV    = ROW_W'(GRAVITY);
  localparam logic [ROW_W-1:0] HALF_V0 = ROW_W'(JUMP_V0 / 2);

  jump_state_e      state_d;
  logic [ROW_W-1:0] height_d;
  logic [ROW_W-1:0] vel, vel_d;
  logic [ROW_W-1:0] speed, speed_d;
  logic [ROW_W-1:0] fall_speed;
  logic [ROW_W:0]   rise_sum;
  logic [LC_W-1:0]  land_cnt, land_cnt_d;
  logic             pending, pending_d;

  assign rise_sum   = {1'b0, height} + {1'b0, vel};
  assign fall_speed = speed + GRAV;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= GROUND;
      height   <= '0;
      vel      <= '0;
      speed    <= '0;
      land_cnt <= '0;
      pending  <= 1'b0;
      airborne <= 1'b0;
    end else begin
      state    <= state_d;
      height   <= height_d;
      vel      <= vel_d;
      speed    <= speed_d;
      land_cnt <= land_cnt_d;
      pending  <= pending_d;
      airborne <= (state_d == RISE) || (state_d == FALL);
    end
  end

  // Comparisons are taken before any subtraction so nothing underflows.
  always_comb begin
    state_d    = state;
    height_d   = height;
    vel_d      = vel;
    speed_d    = speed;
    land_cnt_d = land_cnt;
    pending_d  = pending;
    if (key_rise && (state == GROUND)) pending_d = 1'b1;
    if (tick) begin
      pending_d = 1'b0;
      case (state)
        GROUND: begin
          if (pending || key_rise) begin
            vel_d   = ROW_W'(JUMP_V0);
            state_d = RISE;
          end
        end
        RISE: begin
          height_d = (rise_sum > (ROW_W+1)'(MAX_H)) ? ROW_W'(MAX_H) : rise_sum[ROW_W-1:0];
          if ((vel <= GRAV) || (rise_sum > (ROW_W+1)'(MAX_H))) begin
            state_d = FALL;
            vel_d   = '0;
            speed_d = '0;
          end else begin
            vel_d = vel - GRAV;
          end
        end
        FALL: begin
          speed_d = fall_speed;
          if (fall_speed >= height) begin
            height_d   = '0;
            state_d    = LAND;
            land_cnt_d = '0;
          end else begin
            height_d = height - fall_speed;
          end
        end
        default: begin
          if (land_cnt == LC_W'(LAND_FRAMES - 1)) begin
            state_d    = GROUND;
            land_cnt_d = '0;
          end else begin
            land_cnt_d = land_cnt + LC_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    jump_idx_c = 3'd4;
    case (state)
      RISE:    jump_idx_c = (vel > HALF_V0) ? 3'd0 : 3'd1;
      FALL:    jump_idx_c = (speed < HALF_V0) ? 3'd2 : 3'd3;
      default: jump_idx_c = 3'd4;
    endcase
  end

endmodule

// File: rtl/sprite_animator.sv
// Player-sprite renderer: run animation, jump physics, sprite ROM addressing
// and a two-stage pixel pipeline feeding the layer mixer.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int unsigned COL_W       = 12,
  parameter int unsigned ROW_W       = 11,
  parameter int unsigned SPR_W       = 32,
  parameter int unsigned SPR_H       = 32,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ORIGIN_X    = 220,
  parameter int unsigned GROUND_Y    = 690,
  parameter int unsigned RUN_FRAMES  = 6,
  parameter int unsigned ANIM_TICKS  = 10_000_000,
  parameter int unsigned JUMP_V0     = 22,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned LAND_FRAMES = 3,
  parameter int unsigned ROM_AW      = $clog2((RUN_FRAMES + JUMP_POSES) * SPR_W * SPR_H)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [COL_W-1:0]  display_col,
  input  logic [ROW_W-1:0]  display_row,
  input  logic              visible,
  input  logic              jump_key,
  input  logic              pause,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [3:0]        char_red,
  output logic [3:0]        char_green,
  output logic [3:0]        char_blue,
  output logic              char_visible,
  output logic              airborne,
  output logic [ROW_W-1:0]  char_top
);

  localparam int unsigned SPR_PW  = SPR_W << SCALE_SHIFT;
  localparam int unsigned SPR_PH  = SPR_H << SCALE_SHIFT;
  localparam int unsigned MAX_H   = GROUND_Y - SPR_PH;
  localparam int unsigned SX_W    = $clog2(SPR_W);
  localparam int unsigned SY_W    = $clog2(SPR_H);
  localparam int unsigned FRAME_W = ROM_AW - SX_W - SY_W;
  localparam int unsigned TICK_W  = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam int unsigned RF_W    = (RUN_FRAMES > 1) ? $clog2(RUN_FRAMES) : 1;

  logic               at_origin, at_origin_q, frame_tick, phys_tick, tick_q;
  logic               key_q, key_rise;
  jump_state_e        state;
  logic [ROW_W-1:0]   height;
  logic [2:0]         jump_idx_c;
  logic [TICK_W-1:0]  anim_cnt;
  logic [RF_W-1:0]    run_frame;
  logic [FRAME_W-1:0] frame_c;
  logic [COL_W-1:0]   col_off;
  logic [ROW_W-1:0]   row_off;
  logic [SX_W-1:0]    sx;
  logic [SY_W-1:0]    sy;
  logic               inbox, hit_q;
  rgb_t               px;

  assign at_origin  = (display_col == '0) && (display_row == '0);
  assign frame_tick = at_origin && !at_origin_q;
  assign phys_tick  = frame_tick && !pause;
  assign key_rise   = jump_key && !key_q;

  sprite_jump_physics #(
    .ROW_W       (ROW_W),
    .JUMP_V0     (JUMP_V0),
    .GRAVITY     (GRAVITY),
    .LAND_FRAMES (LAND_FRAMES),
    .MAX_H       (MAX_H)
  ) u_physics (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick       (phys_tick),
    .key_rise   (key_rise),
    .state      (state),
    .height     (height),
    .airborne   (airborne),
    .jump_idx_c (jump_idx_c)
  );

  // Edge detectors, run animation and once-per-frame char_top update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      at_origin_q <= 1'b0;
      key_q       <= 1'b0;
      tick_q      <= 1'b0;
      anim_cnt    <= '0;
      run_frame   <= '0;
      char_top    <= ROW_W'(MAX_H);
    end else begin
      at_origin_q <= at_origin;
      key_q       <= jump_key;
      tick_q      <= phys_tick;
      if (!pause) begin
        if (anim_cnt == TICK_W'(ANIM_TICKS - 1)) begin
          anim_cnt  <= '0;
          run_frame <= (run_frame == RF_W'(RUN_FRAMES - 1)) ? '0 : run_frame + RF_W'(1);
        end else begin
          anim_cnt <= anim_cnt + TICK_W'(1);
        end
      end
      if (tick_q) char_top <= ROW_W'(MAX_H) - height;
    end
  end

  assign col_off = display_col - COL_W'(ORIGIN_X);
  assign row_off = display_row - char_top;
  assign sx      = SX_W'(col_off >> SCALE_SHIFT);
  assign sy      = SY_W'(row_off >> SCALE_SHIFT);
  assign frame_c = (state == GROUND) ? FRAME_W'(run_frame)
                                     : FRAME_W'(RUN_FRAMES) + FRAME_W'(jump_idx_c);
  assign inbox   = (display_col >= COL_W'(ORIGIN_X))
                && ({1'b0, display_col} < (COL_W+1)'(ORIGIN_X + SPR_PW))
                && (display_row >= char_top)
                && ({1'b0, display_row} < ({1'b0, char_top} + (ROW_W+1)'(SPR_PH)));
  assign px      = rom_data;

  // Stage 1 issues the ROM address; stage 2 resolves colour and transparency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr     <= '0;
      hit_q        <= 1'b0;
      char_red     <= COLOUR_BG;
      char_green   <= COLOUR_BG;
      char_blue    <= COLOUR_BG;
      char_visible <= 1'b0;
    end else begin
      rom_addr <= {frame_c, sx, sy};
      hit_q    <= inbox && visible;
      if (hit_q && (rom_data != TRANSPARENT_KEY)) begin
        char_red     <= px.red;
        char_green   <= px.green;
        char_blue    <= px.blue;
        char_visible <= 1'b1;
      end else begin
        char_red     <= COLOUR_BG;
        char_green   <= COLOUR_BG;
        char_blue    <= COLOUR_BG;
        char_visible <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench: default-parameter instance for physics and pixel path,
// fast-animation instance for the run cycle and pause hold.
module tb_sprite_animator;

  localparam int unsigned COL_W  = 12;
  localparam int unsigned ROW_W  = 11;
  localparam int unsigned ROM_AW = 14;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [COL_W-1:0]  col_a = 12'd1;
  logic [ROW_W-1:0]  row_a = 11'd0;
  logic              vis_a = 1'b0, key_a = 1'b0, pause_a = 1'b0;
  logic [11:0]       rom_data_a = 12'h000;
  logic [ROM_AW-1:0] rom_addr_a;
  logic [3:0]        red_a, green_a, blue_a;
  logic              cvis_a, air_a;
  logic [ROW_W-1:0]  top_a;

  logic [COL_W-1:0]  col_b = 12'd225;
  logic [ROW_W-1:0]  row_b = 11'd570;
  logic              vis_b = 1'b1, key_b = 1'b0, pause_b = 1'b0;
  logic [11:0]       rom_data_b = 12'h123;
  logic [ROM_AW-1:0] rom_addr_b;
  logic [3:0]        red_b, green_b, blue_b;
  logic              cvis_b, air_b;
  logic [ROW_W-1:0]  top_b;

  sprite_animator u_dut (
    .clock(clock), .reset_n(reset_n), .display_col(col_a), .display_row(row_a),
    .visible(vis_a), .jump_key(key_a), .pause(pause_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .char_red(red_a), .char_green(green_a), .char_blue(blue_a),
    .char_visible(cvis_a), .airborne(air_a), .char_top(top_a)
  );

  sprite_animator #(.ANIM_TICKS(4), .RUN_FRAMES(6)) u_anim (
    .clock(clock), .reset_n(reset_n), .display_col(col_b), .display_row(row_b),
    .visible(vis_b), .jump_key(key_b), .pause(pause_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .char_red(red_b), .char_green(green_b), .char_blue(blue_b),
    .char_visible(cvis_b), .airborne(air_b), .char_top(top_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_a();
    return int'(rom_addr_a >> 10);
  endfunction

  function automatic int frame_b();
    return int'(rom_addr_b >> 10);
  endfunction

  // One frame tick on instance A, returning once char_top and rom_addr have settled.
  task automatic tick();
    @(negedge clock); col_a = 12'd0; row_a = 11'd0;
    @(negedge clock); col_a = 12'd1; row_a = 11'd0;
    repeat (2) @(negedge clock);
  endtask

  task automatic pix(input string tag, input int col, input int row, input logic vis,
                     input logic [11:0] data, input logic exp_vis, input logic [11:0] exp_rgb);
    @(negedge clock);
    col_a = COL_W'(col); row_a = ROW_W'(row); vis_a = vis; rom_data_a = data;
    repeat (2) @(negedge clock);
    check({tag, "_vis"}, 32'(cvis_a), 32'(exp_vis));
    check({tag, "_rgb"}, 32'({blue_a, green_a, red_a}), 32'(exp_rgb));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h, ef, extra, rises;
    logic prev;

    // Reset values while reset is held.
    repeat (2) @(negedge clock);
    check("rst_addr", 32'(rom_addr_a), 32'd0);
    check("rst_rgb", 32'({blue_a, green_a, red_a}), 32'hFFF);
    check("rst_vis", 32'(cvis_a), 32'd0);
    check("rst_air", 32'(air_a), 32'd0);
    check("rst_top", 32'(top_a), 32'd562);
    reset_n = 1'b1;

    // Run animation: frame steps every 4 clocks, address lags one clock.
    for (int k = 1; k <= 28; k++) begin
      @(negedge clock);
      check($sformatf("anim%0d", k), 32'(frame_b()), 32'(((k - 1) / 4) % 6));
    end
    pause_b = 1'b1;
    repeat (10) @(negedge clock);
    check("pause_hold", 32'(frame_b()), 32'd1);
    pause_b = 1'b0;
    repeat (4) @(negedge clock);
    check("pause_cnt_held", 32'(frame_b()), 32'd1);
    @(negedge clock);
    check("pause_resume", 32'(frame_b()), 32'd2);
    check("anim_vis", 32'(cvis_b), 32'd1);
    check("anim_rgb", 32'({blue_b, green_b, red_b}), 32'h123);
    check("anim_air", 32'(air_b), 32'd0);
    check("anim_top", 32'(top_b), 32'd562);

    // Pixel pipeline: address after one clock, colour after two.
    @(negedge clock);
    col_a = 12'd225; row_a = 11'd571; vis_a = 1'b1; rom_data_a = 12'h3A7;
    @(negedge clock);
    check("addr_first", 32'(rom_addr_a), 32'd34);
    @(negedge clock);
    check("pix_first_vis", 32'(cvis_a), 32'd1);
    check("pix_first_rgb", 32'({blue_a, green_a, red_a}), 32'h3A7);
    col_a = 12'd347; row_a = 11'd689;
    @(negedge clock);
    check("addr_corner", 32'(rom_addr_a), 32'd1023);
    pix("key_c0f",   225, 571, 1'b1, 12'hC0F, 1'b0, 12'hFFF);
    pix("corner_in", 347, 689, 1'b1, 12'h3A7, 1'b1, 12'h3A7);
    pix("origin_in", 220, 562, 1'b1, 12'h0F0, 1'b1, 12'h0F0);
    pix("col_right", 348, 571, 1'b1, 12'h3A7, 1'b0, 12'hFFF);
    pix("col_left",  219, 571, 1'b1, 12'h3A7, 1'b0, 12'hFFF);
    pix("row_above", 225, 561, 1'b1, 12'h3A7, 1'b0, 12'hFFF);
    pix("row_below", 225, 690, 1'b1, 12'h3A7, 1'b0, 12'hFFF);
    pix("blanked",   225, 571, 1'b0, 12'h3A7, 1'b0, 12'hFFF);

    // Jump trajectory with the key held; pose frames 6..10 selected by state.
    @(negedge clock); key_a = 1'b1;
    tick();
    check("rise0_air", 32'(air_a), 32'd1);
    check("rise0_top", 32'(top_a), 32'd562);
    check("rise0_frame", 32'(frame_a()), 32'd6);
    for (int k = 1; k <= 22; k++) begin
      tick();
      h  = 22 * k - (k * (k - 1)) / 2;
      ef = (k == 22) ? 8 : (((22 - k) > 11) ? 6 : 7);
      check($sformatf("rise%0d_top", k), 32'(top_a), 32'(562 - h));
      check($sformatf("rise%0d_frame", k), 32'(frame_a()), 32'(ef));
      check($sformatf("rise%0d_air", k), 32'(air_a), 32'd1);
    end
    for (int k = 1; k <= 22; k++) begin
      tick();
      h  = (k == 22) ? 0 : 253 - (k * (k + 1)) / 2;
      ef = (k == 22) ? 10 : ((k < 11) ? 8 : 9);
      check($sformatf("fall%0d_top", k), 32'(top_a), 32'(562 - h));
      check($sformatf("fall%0d_frame", k), 32'(frame_a()), 32'(ef));
      check($sformatf("fall%0d_air", k), 32'(air_a), (k < 22) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("land%0d_frame", k), 32'(frame_a()), (k < 3) ? 32'd10 : 32'd0);
      check($sformatf("land%0d_air", k), 32'(air_a), 32'd0);
    end

    // Held key: no further jumps for the rest of 200 frames.
    extra = 0;
    for (int k = 0; k < 152; k++) begin
      tick();
      if (air_a) extra++;
    end
    check("hold_one_jump", 32'(extra), 32'd0);

    // Second edge during RISE is discarded.
    @(negedge clock); key_a = 1'b0;
    @(negedge clock); key_a = 1'b1;
    tick();
    check("edge_start_air", 32'(air_a), 32'd1);
    @(negedge clock); key_a = 1'b0;
    tick();
    @(negedge clock); key_a = 1'b1;
    tick();
    @(negedge clock); key_a = 1'b0;
    rises = 0;
    prev  = air_a;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (air_a && !prev) rises++;
      prev = air_a;
    end
    check("edge_no_rejump", 32'(rises), 32'd0);
    check("edge_end_air", 32'(air_a), 32'd0);
    check("edge_end_frame", 32'(frame_a()), 32'd0);

    // Asynchronous reset mid-RISE at height 100.
    @(negedge clock); key_a = 1'b1;
    tick();
    @(negedge clock); key_a = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("mid_top", 32'(top_a), 32'd462);
    pix("mid_pix", 225, 470, 1'b1, 12'h3A7, 1'b1, 12'h3A7);
    #2 reset_n = 1'b0;
    #1;
    check("arst_addr", 32'(rom_addr_a), 32'd0);
    check("arst_rgb", 32'({blue_a, green_a, red_a}), 32'hFFF);
    check("arst_vis", 32'(cvis_a), 32'd0);
    check("arst_air", 32'(air_a), 32'd0);
    check("arst_top", 32'(top_a), 32'd562);
    @(negedge clock); reset_n = 1'b1;
    tick();
    check("post_rst_air", 32'(air_a), 32'd0);
    check("post_rst_frame", 32'(frame_a()), 32'd0);
    check("post_rst_top", 32'(top_a), 32'd562);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Parametrised player-sprite renderer for the VGA pixel pipeline. It runs a run-cycle animation and a velocity/gravity jump state machine, and fetches sprite pixels from an external synchronous sprite ROM. It returns colour and a visibility flag per pixel to the layer mixer. It is the successor to the fixed-size, table-driven character block, adding integer scaling, configurable sprite geometry, parametric jump physics, pause, and a landing phase.

## Interface
- COL_W, 12: display_col width
- ROW_W, 11: display_row width
- SPR_W, 32: source sprite width in ROM pixels (power of 2)
- SPR_H, 32: source sprite height in ROM pixels (power of 2)
- SCALE_SHIFT, 2: on-screen size is source size << SCALE_SHIFT
- ORIGIN_X, 220: left screen column of the sprite
- GROUND_Y, 690: screen row of the sprite bottom when height = 0
- RUN_FRAMES, 6: run animation frames
- ANIM_TICKS, 10_000_000: clocks per run-animation step
- JUMP_V0, 22: initial upward velocity, in rows per video frame
- GRAVITY, 1: velocity change per video frame
- LAND_FRAMES, 3: video frames spent in LAND
- ROM_AW, derived: clog2((RUN_FRAMES+5)·SPR_W·SPR_H)
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- display_col  in  COL_W  current pixel column
- display_row  in  ROW_W  current pixel row
- visible  in  1  active video region
- jump_key  in  1  jump button, level, already synchronised
- pause  in  1  freezes physics and animation; drawing continues
- rom_addr  out  ROM_AW  sprite ROM address (registered)
- rom_data  in  12  ROM word, valid 1 clock after rom_addr; format {B[11:8],G[7:4],R[3:0]}
- char_red, char_green, char_blue  out  4 each  pixel colour
- char_visible  out  1  sprite pixel is opaque
- airborne  out  1  state is RISE or FALL
- char_top  out  ROW_W  current sprite top row; updated once per video frame

## Operation
- Frame tick: a 1-clock pulse on the rising edge of (display_col==0 && display_row==0). It fires only once, even if that condition holds for several clocks. Physics and char_top update only on a frame tick with pause low.
- Jump request: a rising edge of jump_key sets `pending`. `pending` is cleared on the next frame tick. A holding key does not retrigger. An edge while not in GROUND is discarded.
- States: GROUND, RISE, FALL, LAND. Transitions are evaluated on frame ticks:
  - GROUND: if pending, set vel=JUMP_V0 and go to RISE.
  - RISE: height += vel, then vel -= GRAVITY. If vel ≤ GRAVITY before the subtract, go to FALL with speed=0. If the new height would exceed MAX_H = GROUND_Y − (SPR_H<<SCALE_SHIFT), clamp height to MAX_H and go to FALL.
  - FALL: speed += GRAVITY, then height −= speed. If speed ≥ height, set height=0 and go to LAND.
  - LAND: count LAND_FRAMES ticks, then go to GROUND.
- Jump frame index: RISE gives 0 if vel > JUMP_V0/2, else 1. FALL gives 2 if speed < JUMP_V0/2, else 3. LAND gives 4.
- Run animation: the tick counter counts 0..ANIM_TICKS−1 and wraps. On wrap, run_frame increments modulo RUN_FRAMES. Counter and frame are held while pause is high.
- ROM layout: frames 0..RUN_FRAMES−1 hold the run cycle, and frames RUN_FRAMES..RUN_FRAMES+4 hold the jump poses. Address = frame·SPR_W·SPR_H + {sx, sy}, where sx = (col−ORIGIN_X)>>SCALE_SHIFT and sy = (row−char_top)>>SCALE_SHIFT.
- Frame selection: in GROUND the active frame is run_frame; in every other state it is RUN_FRAMES + jump index.
- Hit box: ORIGIN_X ≤ col < ORIGIN_X+(SPR_W<<S) and char_top ≤ row < char_top+(SPR_H<<S).
- Pixel output: a pixel is opaque when it is inside the hit box, visible is high, and rom_data ≠ 12'hC0F (transparent key). Opaque pixels drive colour from rom_data with char_visible=1. All other pixels drive colour 4'hF on every channel with char_visible=0.

## Timing
- Pixel path latency is 2 clocks from display_col/display_row to the char_* outputs:
  - Stage 1 registers rom_addr, inbox and visible.
  - Stage 2 registers the colour outputs from rom_data.
- char_top is computed as GROUND_Y − (SPR_H<<S) − height and registered 1 clock after the frame tick. It is stable for the rest of the frame.
- Reset values:
  - Outputs: rom_addr=0, colours=4'hF, char_visible=0, airborne=0, char_top=GROUND_Y−(SPR_H<<S).
  - Internal: state=GROUND, height=0, vel=0, speed=0, pending=0, run_frame=0, tick counter=0.
- Reset asserted mid-jump returns to GROUND immediately and asynchronously. No partial landing is performed.
- A jump_key edge coinciding with a frame tick counts as pending for that tick.
- Arithmetic: height, vel and speed are ROW_W-bit unsigned. All comparisons are made before subtraction, so no underflow is possible.

## Structure
- Package `sprite_pkg` holds:
  - the state enum (GROUND/RISE/FALL/LAND);
  - TRANSPARENT_KEY = 12'hC0F;
  - COLOUR_BG = 4'hF;
  - JUMP_POSES = 5.
- Sub-module `sprite_jump_physics` contains the frame-tick-driven state machine, pending latch, height, vel, speed, LAND counter and jump index. The top level keeps the run animation counter, address generation and pixel pipeline.

## Test plan
- Jump trajectory (defaults): one jump_key edge, then frame ticks. Required response:
  - height rises 22, 43, 63, … and reaches 253 on tick 22, then FALL;
  - height falls 252, 250, 247, … and reaches 0 on the 22nd FALL tick, then LAND;
  - GROUND is re-entered after 3 ticks.
- Key handling: hold jump_key high for 200 frames → exactly one jump. An edge during RISE → ignored, with no second jump after landing.
- Run animation: set ANIM_TICKS=4 and RUN_FRAMES=6 → run_frame steps 0,1,…,5,0 every 4 clocks. Assert pause for 10 clocks → frame and counter are held.
- Pixel pipeline: col=ORIGIN_X+5, row=char_top+9, SCALE_SHIFT=2 → rom_addr = run_frame·1024 + {5'd1, 5'd2} one clock later. rom_data=12'h3A7 → R=7, G=A, B=3, visible=1 on the second clock.
- Transparency and edges:
  - rom_data=12'hC0F inside the box → char_visible=0, colours F.
  - col=ORIGIN_X+128 → outside the box.
  - visible=0 → char_visible=0.
- Reset: assert reset_n=0 at RISE height 100 → all outputs take their reset values asynchronously, and after release state is GROUND with char_top=562.
